// File: rtl/bytewrite_sdp_ram_pipe.sv
// Simple-dual-port RAM with per-column byte-write enables, selectable
// collision behaviour (write-first per column or read-first), optional
// output register stage, and a post-reset clear sweep that zeroes every
// location before user traffic is accepted.
// Optional feature macro: SDP_RAM_PARITY_EN (per-column even parity storage
// and read-side parity error reporting).
module bytewrite_sdp_ram_pipe #(
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
    parameter int READ_MODE  = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [NUM_COL-1:0]    we,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  init_done,
    output logic [NUM_COL-1:0]    par_err
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  rd_fire, wr_fire, hit;
    logic [NUM_COL-1:0]    fwd_mask;
    logic [DATA_WIDTH-1:0] rd_old, rd_data;
    logic [NUM_COL-1:0]    rd_perr;

    logic                  s1_vld_q;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic [NUM_COL-1:0]    s1_perr_q;

    // FSM state and clear-address register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Clear sweep walks every address once, then parks in READY for good
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            S_CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                if (clr_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = S_READY;
                end
            end
            default: ;
        endcase
    end

    assign init_done = (state_q == S_READY);

    // User traffic is only honoured once the sweep has finished
    assign rd_fire  = rd_en && (state_q == S_READY);
    assign wr_fire  = wr_en && (state_q == S_READY);
    assign hit      = wr_fire && (write_addr == read_addr);
    assign fwd_mask = (READ_MODE == 0 && hit) ? we : '0;
    assign rd_old   = mem_q[read_addr];

    // Data storage: clear sweep has priority, otherwise byte-masked writes
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_COL; i++) begin
                if (we[i]) begin
                    mem_q[write_addr][i*COL_WIDTH +: COL_WIDTH] <= din[i*COL_WIDTH +: COL_WIDTH];
                end
            end
        end
    end

    // Write-first collisions substitute the incoming column per enabled byte
    always_comb begin
        rd_data = rd_old;
        for (int i = 0; i < NUM_COL; i++) begin
            if (fwd_mask[i]) begin
                rd_data[i*COL_WIDTH +: COL_WIDTH] = din[i*COL_WIDTH +: COL_WIDTH];
            end
        end
    end

`ifdef SDP_RAM_PARITY_EN
    logic [NUM_COL-1:0] par_q [DEPTH];

    function automatic logic [NUM_COL-1:0] col_parity(input logic [DATA_WIDTH-1:0] d);
        logic [NUM_COL-1:0] p;
        for (int i = 0; i < NUM_COL; i++) begin
            p[i] = ^d[i*COL_WIDTH +: COL_WIDTH];
        end
        return p;
    endfunction

    // Parity storage tracks the data array column for column
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            par_q[clr_cnt_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_COL; i++) begin
                if (we[i]) begin
                    par_q[write_addr][i] <= ^din[i*COL_WIDTH +: COL_WIDTH];
                end
            end
        end
    end

    // Forwarded columns come straight from din, so they cannot be corrupt
    assign rd_perr = (col_parity(rd_old) ^ par_q[read_addr]) & ~fwd_mask;
`else
    assign rd_perr = '0;
`endif

    // First read stage: data holds between reads, valid/parity pulse per read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s1_perr_q <= '0;
        end else begin
            s1_vld_q  <= rd_fire;
            s1_perr_q <= rd_fire ? rd_perr : '0;
            if (rd_fire) begin
                s1_data_q <= rd_data;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic                  s2_vld_q;
            logic [DATA_WIDTH-1:0] s2_data_q;
            logic [NUM_COL-1:0]    s2_perr_q;

            // Second read stage adds one cycle of latency, same hold rules
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_vld_q  <= 1'b0;
                    s2_data_q <= '0;
                    s2_perr_q <= '0;
                end else begin
                    s2_vld_q  <= s1_vld_q;
                    s2_perr_q <= s1_perr_q;
                    if (s1_vld_q) begin
                        s2_data_q <= s1_data_q;
                    end
                end
            end

            assign dout       = s2_data_q;
            assign dout_valid = s2_vld_q;
            assign par_err    = s2_perr_q;
        end else begin : g_noreg
            assign dout       = s1_data_q;
            assign dout_valid = s1_vld_q;
            assign par_err    = s1_perr_q;
        end
    endgenerate

endmodule

// File: tb/tb_bytewrite_sdp_ram_pipe.sv
// Randomized bench for bytewrite_sdp_ram_pipe with a behavioural reference
// model (flat memory array plus a queue of scheduled read results).
module tb_bytewrite_sdp_ram_pipe;
    parameter int RM  = 0;
    parameter int ORG = 0;

    localparam int NC    = 4;
    localparam int CW    = 8;
    localparam int AW    = 10;
    localparam int DW    = NC * CW;
    localparam int DEPTH = 2 ** AW;
    localparam int LAT   = (ORG != 0) ? 2 : 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_en = 1'b0;
    logic [NC-1:0] we = '0;
    logic [AW-1:0] write_addr = '0;
    logic [DW-1:0] din = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] read_addr = '0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          init_done;
    logic [NC-1:0] par_err;

    always #5 clk = ~clk;

    bytewrite_sdp_ram_pipe #(
        .NUM_COL(NC), .COL_WIDTH(CW), .ADDR_WIDTH(AW),
        .READ_MODE(RM), .OUT_REG(ORG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .we(we),
        .write_addr(write_addr), .din(din), .rd_en(rd_en),
        .read_addr(read_addr), .dout(dout), .dout_valid(dout_valid),
        .init_done(init_done), .par_err(par_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    typedef struct {
        int            due;
        logic [DW-1:0] d;
        logic [NC-1:0] pe;
    } rd_t;

    logic [DW-1:0] m_mem [DEPTH];
    logic [NC-1:0] m_bad [DEPTH];
    rd_t           pend[$];
    int            edges;
    int            ecount = 0;
    logic [DW-1:0] e_dout;
    logic          e_vld;
    logic [NC-1:0] e_perr;

    task automatic model_reset();
        for (int a = 0; a < DEPTH; a++) begin
            m_mem[a] = '0;
            m_bad[a] = '0;
        end
        pend.delete();
        edges  = 0;
        e_dout = '0;
        e_vld  = 1'b0;
        e_perr = '0;
    endtask

    // One clock edge: update the model from the inputs, then compare outputs
    task automatic step();
        rd_t r;
        @(posedge clk);
        ecount++;
        edges++;
        if (edges > DEPTH) begin
            if (rd_en) begin
                r.d  = m_mem[read_addr];
                r.pe = m_bad[read_addr];
                if (RM == 0 && wr_en && write_addr == read_addr) begin
                    for (int i = 0; i < NC; i++) begin
                        if (we[i]) begin
                            r.d[i*CW +: CW] = din[i*CW +: CW];
                            r.pe[i] = 1'b0;
                        end
                    end
                end
                r.due = ecount + LAT - 1;
                pend.push_back(r);
            end
            if (wr_en) begin
                for (int i = 0; i < NC; i++) begin
                    if (we[i]) begin
                        m_mem[write_addr][i*CW +: CW] = din[i*CW +: CW];
                        m_bad[write_addr][i] = 1'b0;
                    end
                end
            end
        end
        e_vld  = 1'b0;
        e_perr = '0;
        if (pend.size() > 0 && pend[0].due == ecount) begin
            e_vld  = 1'b1;
            e_dout = pend[0].d;
            e_perr = pend[0].pe;
            pend.delete(0);
        end
        #1;
        chk_val("dout_valid", DW'(dout_valid), DW'(e_vld));
        chk_val("dout", dout, e_dout);
        chk_val("par_err", DW'(par_err), DW'(e_perr));
        chk_val("init_done", DW'(init_done), DW'(edges >= DEPTH));
    endtask

    task automatic drv(input logic w, input logic [NC-1:0] m, input int wa,
                       input logic [DW-1:0] d, input logic r, input int ra);
        wr_en      = w;
        we         = m;
        write_addr = wa[AW-1:0];
        din        = d;
        rd_en      = r;
        read_addr  = ra[AW-1:0];
        step();
    endtask

    task automatic idle();
        drv(1'b0, '0, 0, '0, 1'b0, 0);
    endtask

    task automatic rand_step(input int amax);
        drv(1'($urandom_range(0, 1)), NC'($urandom), $urandom_range(0, amax),
            $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, amax));
    endtask

    // Issue one read and return once its result should be on dout
    task automatic rd_chk(input int a, input logic [DW-1:0] exp, input string tag);
        drv(1'b0, '0, 0, '0, 1'b1, a);
        repeat (LAT - 1) idle();
        chk_val(tag, dout, exp);
        chk_val({tag, "_vld"}, DW'(dout_valid), DW'(1));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        chk_val("rst_dout", dout, '0);
        chk_val("rst_vld", DW'(dout_valid), '0);
        chk_val("rst_init", DW'(init_done), '0);
        chk_val("rst_perr", DW'(par_err), '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        apply_reset();
        // Clear sweep with random traffic that must be ignored
        repeat (DEPTH) rand_step(15);
        idle();

        rd_chk(0, 32'h0, "rd_a0");
        rd_chk(511, 32'h0, "rd_a511");
        rd_chk(1023, 32'h0, "rd_a1023");
        idle();

        drv(1'b1, 4'b1111, 5, 32'hAABBCCDD, 1'b0, 0);
        drv(1'b1, 4'b0101, 5, 32'h11223344, 1'b0, 0);
        rd_chk(5, 32'hAA22CC44, "bytemask");
        drv(1'b1, 4'b0000, 5, 32'hFFFFFFFF, 1'b0, 0);
        rd_chk(5, 32'hAA22CC44, "we_zero");
        idle();

        drv(1'b1, 4'b1111, 7, 32'h01020304, 1'b0, 0);
        drv(1'b1, 4'b1000, 7, 32'hF0F0F0F0, 1'b1, 7);
        repeat (LAT - 1) idle();
        chk_val("collision", dout, (RM == 0) ? 32'hF0020304 : 32'h01020304);
        rd_chk(7, 32'hF0020304, "post_coll");
        idle();

        for (int a = 1; a <= 3; a++) drv(1'b1, 4'b1111, a, DW'(a), 1'b0, 0);
        for (int i = 0; i < 3 + LAT; i++) begin
            drv(1'b0, '0, 0, '0, 1'(i < 3), i + 1);
            if (i >= LAT - 1 && i < LAT + 2) begin
                chk_val("pipe", dout, DW'(i - LAT + 2));
            end
        end
        idle();

`ifdef SDP_RAM_PARITY_EN
        drv(1'b1, 4'b1111, 9, 32'h000000FF, 1'b0, 0);
        drv(1'b1, 4'b1111, 8, 32'h12345678, 1'b0, 0);
        dut.par_q[9][0] = ~dut.par_q[9][0];
        m_bad[9][0] = 1'b1;
        rd_chk(9, 32'h000000FF, "par_rd9");
        chk_val("par_err9", DW'(par_err), DW'(4'b0001));
        rd_chk(8, 32'h12345678, "par_rd8");
        chk_val("par_err8", DW'(par_err), '0);
        idle();
`endif

        // Dense random traffic on a small window to provoke collisions
        repeat (2500) rand_step(15);
        repeat (300) rand_step(DEPTH - 1);
        idle();

        // Reset in the middle of a fresh sweep, with traffic throughout
        apply_reset();
        repeat (300) rand_step(15);
        apply_reset();
        repeat (DEPTH) rand_step(15);
        for (int a = 0; a < 16; a++) rd_chk(a, 32'h0, "post_clr");
        repeat (400) rand_step(15);
        repeat (LAT + 1) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
